// File: rtl/countdown_timer8_pkg.sv
// Shared definitions for the loadable down-counter and its control interface.
package countdown_timer8_pkg;

    localparam int unsigned COUNT_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // The last decrement happens from 1, so the counter itself never has to test for zero.
    function automatic logic is_terminal(input logic [COUNT_W-1:0] cnt);
        return cnt == COUNT_W'(1);
    endfunction

endpackage

// File: rtl/countdown_timer8_if.sv
// Control and status bundle between a timer owner (master) and the timer (slave).
interface countdown_timer8_if
    import countdown_timer8_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_W
);

    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             expired;

    modport master (
        output start,
        output load_val,
        output en,
        output abort,
        input  count,
        input  busy,
        input  done,
        input  expired
    );

    modport slave (
        input  start,
        input  load_val,
        input  en,
        input  abort,
        output count,
        output busy,
        output done,
        output expired
    );

endinterface

// File: rtl/countdown_timer8.sv
// Loadable down-counter with start/abort, optional auto-reload and a registered done pulse.
module countdown_timer8
    import countdown_timer8_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNT_W,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer8_if.slave  ctl_io
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             busy_q;
    logic             done_q;
    logic             expired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ctl_io.abort) begin
                state_q   <= StIdle;
                count_q   <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (ctl_io.start) begin
                            if (ctl_io.load_val != '0) begin
                                state_q   <= StRun;
                                count_q   <= ctl_io.load_val;
                                reload_q  <= ctl_io.load_val;
                                busy_q    <= 1'b1;
                                expired_q <= 1'b0;
                            end else begin
                                // Zero load: terminal count is reached without ever running.
                                state_q   <= StDone;
                                count_q   <= '0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                expired_q <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (ctl_io.en) begin
                            if (is_terminal(COUNT_W'(count_q))) begin
                                done_q    <= 1'b1;
                                expired_q <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    // Skip the zero so the downstream zero flag never fires.
                                    count_q <= reload_q;
                                end else begin
                                    state_q <= StDone;
                                    count_q <= '0;
                                    busy_q  <= 1'b0;
                                end
                            end else if (count_q != '0) begin
                                count_q <= count_q - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctl_io.count   = count_q;
    assign ctl_io.busy    = busy_q;
    assign ctl_io.done    = done_q;
    assign ctl_io.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer8.sv
// Directed bench for countdown_timer8: one-shot and auto-reload instances side by side.
module tb_countdown_timer8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    countdown_timer8_if #(.WIDTH(8)) bus_a ();
    countdown_timer8_if #(.WIDTH(8)) bus_b ();

    countdown_timer8 #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .ctl_io (bus_a.slave)
    );

    countdown_timer8 #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .ctl_io (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int cnt, input bit busy, input bit done,
                           input bit expired);
        check_eq({tag, ".count"},   32'(bus_a.count),   32'(cnt));
        check_eq({tag, ".busy"},    32'(bus_a.busy),    32'(busy));
        check_eq({tag, ".done"},    32'(bus_a.done),    32'(done));
        check_eq({tag, ".expired"}, 32'(bus_a.expired), 32'(expired));
    endtask

    // Expected counts for load 4 with en alternating 1,0,1,0,...
    int toggle_cnt [7] = '{3, 3, 2, 2, 1, 1, 0};
    // Expected counts for auto-reload load 2 with en held high.
    int reload_cnt [6] = '{1, 2, 1, 2, 1, 2};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.load_val = '0; bus_a.en = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.load_val = '0; bus_b.en = 1'b0; bus_b.abort = 1'b0;
        tick();
        tick();
        check_a("reset", 0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.b_count", 32'(bus_b.count), 32'd0);
        rst = 1'b0;
        tick();

        // Load 3, en high: 3,2,1,0 with done on the zero cycle.
        bus_a.start = 1'b1; bus_a.load_val = 8'd3; bus_a.en = 1'b1;
        tick();
        bus_a.start = 1'b0; bus_a.load_val = 8'd0;
        check_a("l3.e1", 3, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("l3.e2", 2, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("l3.e3", 1, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("l3.e4", 0, 1'b0, 1'b1, 1'b1);
        check_eq("l3.zero_det", 32'(bus_a.count == 8'd0), 32'd1);
        tick();
        check_a("l3.e5", 0, 1'b0, 1'b0, 1'b1);

        // Reset asserted asynchronously mid-run after two decrements.
        bus_a.start = 1'b1; bus_a.load_val = 8'd5;
        tick();
        bus_a.start = 1'b0; bus_a.load_val = 8'd0;
        tick();
        tick();
        check_a("rmid.pre", 3, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_a("rmid.async", 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("rmid.after", 0, 1'b0, 1'b0, 1'b0);
        end

        // Load 4 with en toggling: count holds on en=0, done after 8 cycles.
        bus_a.start = 1'b1; bus_a.load_val = 8'd4; bus_a.en = 1'b1;
        tick();
        bus_a.start = 1'b0; bus_a.load_val = 8'd0;
        check_a("tog.load", 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bus_a.en = (i % 2 == 0);
            tick();
            check_a("tog.step", toggle_cnt[i], (i != 6), (i == 6), (i == 6));
        end
        bus_a.en = 1'b1;

        // Abort from DONE clears expired and returns to idle.
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check_a("abort.done", 0, 1'b0, 1'b0, 1'b0);

        // Zero load: straight to DONE, done pulse next cycle, busy never rises.
        bus_a.start = 1'b1; bus_a.load_val = 8'd0;
        tick();
        bus_a.start = 1'b0;
        check_a("l0.e1", 0, 1'b0, 1'b1, 1'b1);
        tick();
        check_a("l0.e2", 0, 1'b0, 1'b0, 1'b1);

        // Load 2, abort coincides with the final decrement: abort wins, no done.
        bus_a.start = 1'b1; bus_a.load_val = 8'd2;
        tick();
        bus_a.start = 1'b0; bus_a.load_val = 8'd0;
        check_a("ab.e1", 2, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("ab.e2", 1, 1'b1, 1'b0, 1'b0);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check_a("ab.e3", 0, 1'b0, 1'b0, 1'b0);
        tick();
        check_a("ab.e4", 0, 1'b0, 1'b0, 1'b0);

        // Start during RUN is ignored.
        bus_a.start = 1'b1; bus_a.load_val = 8'd9; bus_a.en = 1'b0;
        tick();
        check_a("sr.load9", 9, 1'b1, 1'b0, 1'b0);
        bus_a.load_val = 8'd7; bus_a.en = 1'b1;
        tick();
        bus_a.start = 1'b0; bus_a.load_val = 8'd0;
        check_a("sr.ignored", 8, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("sr.cont", 7, 1'b1, 1'b0, 1'b0);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check_a("sr.abort", 0, 1'b0, 1'b0, 1'b0);

        // Auto-reload instance: load 2 gives 2,1,2,1,... and never shows zero.
        bus_b.start = 1'b1; bus_b.load_val = 8'd2; bus_b.en = 1'b1;
        tick();
        bus_b.start = 1'b0; bus_b.load_val = 8'd0;
        check_eq("ar.load", 32'(bus_b.count), 32'd2);
        check_eq("ar.busy", 32'(bus_b.busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("ar.count", 32'(bus_b.count), 32'(reload_cnt[i]));
            check_eq("ar.done", 32'(bus_b.done), 32'(i % 2 == 1));
            check_eq("ar.busy_run", 32'(bus_b.busy), 32'd1);
            check_eq("ar.expired", 32'(bus_b.expired), 32'(i >= 1));
        end
        bus_b.abort = 1'b1;
        tick();
        bus_b.abort = 1'b0;
        check_eq("ar.abort_count", 32'(bus_b.count), 32'd0);
        check_eq("ar.abort_busy", 32'(bus_b.busy), 32'd0);
        check_eq("ar.abort_done", 32'(bus_b.done), 32'd0);
        check_eq("ar.abort_exp", 32'(bus_b.expired), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer8.md
Name: countdown_timer8

Overview:
- Loadable 8-bit down-counter with start/abort control and a terminal-count pulse.
- Sits directly upstream of the team's 8-input all-zero detector. The `count` output drives that detector's 8-bit input, so the detector's output flags "timer at zero" for downstream logic.
- The block also generates its own registered `done` pulse, so consumers need not edge-detect the combinational zero flag.

Parameters:
- WIDTH, 8, counter and load-value width. Must stay 8 when feeding the zero detector.
- AUTO_RELOAD, 0, 1 = reload the latched start value on reaching zero and keep running. 0 = stop in DONE.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request: latch `load_val` and begin counting
- load_val  input  WIDTH  initial count, sampled only when `start` is accepted
- en  input  1  count enable; decrement occurs only when en=1
- abort  input  1  stop counting immediately and return to IDLE
- count  output  WIDTH  current count (feeds the zero detector)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when count reaches 0 by decrement
- expired  output  1  sticky: timer reached terminal count since last start/abort

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset: state=IDLE, count=0, busy=0, done=0, expired=0, reload register=0. Reset may be asserted mid-RUN; it forces these values immediately with no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.

State machine:
- IDLE
  - start=1 and load_val≠0: count←load_val, reload register←load_val, expired←0, go RUN.
  - start=1 and load_val=0: go DONE, done=1 next cycle, expired←1, count stays 0.
- RUN
  - busy=1.
  - Each edge with en=1, count←count-1.
  - If the current count=1 and en=1: count←0, done=1 for the following cycle, expired←1. Then:
    - AUTO_RELOAD=0: go DONE.
    - AUTO_RELOAD=1: count←reload register instead of 0, stay RUN.
  - en=0: count holds.
- DONE
  - busy=0, count=0.
  - start re-arms exactly as from IDLE.
  - abort: go IDLE, expired←0.

Priority and boundary rules:
- Priority each edge: rst > abort > terminal/decrement > start.
- abort in RUN: count←0, go IDLE, no done pulse, expired←0. This holds even if count=1 with en=1 in the same cycle.
- start while in RUN is ignored (no restart, load_val not sampled).
- Counter never wraps below 0. No decrement occurs in IDLE or DONE.
- Timing: start sampled at edge 0 with load_val=N, en held at 1:
  - count=N after edge 1;
  - count=0 after edge N+1;
  - done high for exactly the cycle after edge N+1;
  - busy high from edge 1 to edge N+1.
- AUTO_RELOAD=1 with the zero detector downstream: count never shows 0 during reload. Consumers rely on `done`, not the zero flag, in that mode.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and COUNT_W=8.
- No sub-module needed. The terminal-count compare (count==1) is internal.
- The zero detection of `count` is done by the existing downstream zero-detect stage and is not duplicated here.

Test Plan:
- Reset mid-RUN (load 5, assert rst after 2 counts) → count=0, busy=0, done=0, expired=0 immediately; no done pulse afterwards.
- start with load_val=3, en=1 → count sequence 3,2,1,0; done high one cycle after count reaches 0; busy high 3 cycles; expired=1; downstream zero detector out=1.
- start with load_val=4, en toggled 1,0,1,0,... → count holds on en=0 cycles; done arrives after 8 cycles.
- start with load_val=0 → no RUN; done pulses next cycle; expired=1; busy never asserts.
- load 2 with abort and the final decrement in the same cycle → state IDLE, count=0, no done; start during RUN (load 9 then start with 7) → ignored, count continues from 9.
- AUTO_RELOAD=1, load 2 → count 2,1,2,1,...; done pulses every 2 cycles; count never 0; abort → IDLE.
